// File: rtl/switch_islip_sched.sv
// Single-iteration iSLIP scheduler for an input-queued crossbar.
// Matches are locked per packet and released on pkt_done.
module switch_islip_sched #(
  parameter  int RADIX = 4,
  localparam int PTR_W = (RADIX > 1) ? $clog2(RADIX) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RADIX*RADIX-1:0] voq_req,
  input  logic [RADIX-1:0]       pkt_done,
  input  logic [RADIX-1:0]       out_en,
  output logic [RADIX*RADIX-1:0] match,
  output logic [RADIX-1:0]       in_busy,
  output logic [RADIX-1:0]       out_busy,
  output logic [RADIX-1:0]       match_new
);

  logic [RADIX-1:0] match_row_reg [RADIX];
  logic [RADIX-1:0] match_new_reg;
  logic [PTR_W-1:0] g_ptr_reg [RADIX];
  logic [PTR_W-1:0] a_ptr_reg [RADIX];

  logic [RADIX-1:0] in_busy_w;
  logic [RADIX-1:0] out_busy_w;
  logic [RADIX-1:0] out_free;
  // *_col arrays are indexed by output (bits = inputs), *_row by input (bits = outputs)
  logic [RADIX-1:0] req_col  [RADIX];
  logic [RADIX-1:0] gnt_col  [RADIX];
  logic [RADIX-1:0] gnt_row  [RADIX];
  logic [RADIX-1:0] acc_row  [RADIX];
  logic [RADIX-1:0] acc_col  [RADIX];
  logic [RADIX-1:0] busy_col [RADIX];

  // One-hot pick of the first set bit at or after ptr, wrapping modulo RADIX.
  function automatic logic [RADIX-1:0] rr_pick(input logic [RADIX-1:0] reqs,
                                               input logic [PTR_W-1:0] ptr);
    logic [RADIX-1:0] pick;
    logic             found;
    int               idx;
    logic [PTR_W-1:0] sel;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < RADIX; k++) begin
      idx = int'(ptr) + k;
      if (idx >= RADIX) idx = idx - RADIX;
      sel = idx[PTR_W-1:0];
      if (!found && reqs[sel]) begin
        pick[sel] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PTR_W-1:0] oh_idx(input logic [RADIX-1:0] oh);
    logic [PTR_W-1:0] r;
    r = '0;
    for (int k = 0; k < RADIX; k++) begin
      if (oh[k]) r = PTR_W'(k);
    end
    return r;
  endfunction

  // Explicit wrap compare keeps non-power-of-two radices correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RADIX - 1)) ? '0 : p + 1'b1;
  endfunction

  genvar gi, gj;
  generate
    for (gi = 0; gi < RADIX; gi++) begin : g_in
      assign in_busy_w[gi]                = |match_row_reg[gi];
      assign match[gi*RADIX +: RADIX]     = match_row_reg[gi];

      for (gj = 0; gj < RADIX; gj++) begin : g_x
        assign req_col[gj][gi]  = voq_req[gi*RADIX+gj] & ~in_busy_w[gi] & out_free[gj];
        assign gnt_row[gi][gj]  = gnt_col[gj][gi];
        assign acc_col[gj][gi]  = acc_row[gi][gj];
        assign busy_col[gj][gi] = match_row_reg[gi][gj];
      end

      // A locked input receives no grants, so acc_row is zero while it is busy.
      assign acc_row[gi] = rr_pick(gnt_row[gi], a_ptr_reg[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          match_row_reg[gi] <= '0;
          match_new_reg[gi] <= 1'b0;
          a_ptr_reg[gi]     <= '0;
        end else begin
          match_new_reg[gi] <= |acc_row[gi];
          if (|acc_row[gi]) begin
            match_row_reg[gi] <= acc_row[gi];
            a_ptr_reg[gi]     <= ptr_inc(oh_idx(acc_row[gi]));
          end else if (pkt_done[gi]) begin
            match_row_reg[gi] <= '0;
          end
        end
      end
    end

    for (gi = 0; gi < RADIX; gi++) begin : g_out
      assign out_busy_w[gi] = |busy_col[gi];
      assign out_free[gi]   = out_en[gi] & ~out_busy_w[gi];
      assign gnt_col[gi]    = rr_pick(req_col[gi], g_ptr_reg[gi]);

      // Grant pointer only moves when its grant was accepted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          g_ptr_reg[gi] <= '0;
        end else if (|acc_col[gi]) begin
          g_ptr_reg[gi] <= ptr_inc(oh_idx(acc_col[gi]));
        end
      end
    end
  endgenerate

  assign in_busy   = in_busy_w;
  assign out_busy  = out_busy_w;
  assign match_new = match_new_reg;

endmodule

// File: tb/tb_switch_islip_sched.sv
// Directed bench for switch_islip_sched (RADIX=4) with hand-computed expected matches.
module tb_switch_islip_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] voq_req;
  logic [3:0]  pkt_done;
  logic [3:0]  out_en;
  logic [15:0] match;
  logic [3:0]  in_busy;
  logic [3:0]  out_busy;
  logic [3:0]  match_new;

  int n_checks = 0;
  int n_fail   = 0;
  int order [5] = '{0, 1, 2, 3, 0};
  int ii;
  logic [15:0] m_exp;

  switch_islip_sched #(.RADIX(4)) dut (
    .clk(clk), .rst_n(rst_n), .voq_req(voq_req), .pkt_done(pkt_done), .out_en(out_en),
    .match(match), .in_busy(in_busy), .out_busy(out_busy), .match_new(match_new)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] row_or(input logic [15:0] m);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = |m[i*4 +: 4];
    return r;
  endfunction

  function automatic logic [3:0] col_or(input logic [15:0] m);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        r[j] = r[j] | m[i*4+j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_state(input string tag, input logic [15:0] m, input logic [3:0] mn);
    chk({tag, ".match"}, 32'(match), 32'(m));
    chk({tag, ".match_new"}, 32'(match_new), 32'(mn));
    chk({tag, ".in_busy"}, 32'(in_busy), 32'(row_or(m)));
    chk({tag, ".out_busy"}, 32'(out_busy), 32'(col_or(m)));
    $display("step %s: match=%h match_new=%b in_busy=%b out_busy=%b",
             tag, match, match_new, in_busy, out_busy);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    voq_req  = '0;
    pkt_done = '0;
    out_en   = 4'hf;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    voq_req  = '0;
    pkt_done = '0;
    out_en   = 4'hf;
    #1;
    expect_state("reset", 16'h0000, 4'b0000);
    tick();
    rst_n = 1'b1;

    // Single connection in1->out2, free-input pkt_done ignored, release.
    reset_dut();
    voq_req = 16'h0040;
    tick();
    expect_state("t1_match", 16'h0040, 4'b0010);
    tick();
    expect_state("t1_hold", 16'h0040, 4'b0000);
    pkt_done = 4'b1000;
    tick();
    pkt_done = '0;
    expect_state("t1_free_done", 16'h0040, 4'b0000);
    voq_req  = '0;
    pkt_done = 4'b0010;
    tick();
    pkt_done = '0;
    expect_state("t1_release", 16'h0000, 4'b0000);

    // All inputs contend for out0: round-robin order 0,1,2,3,0.
    reset_dut();
    voq_req = 16'h1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      ii    = order[n];
      m_exp = 16'h0001 << (4 * ii);
      expect_state($sformatf("t2_grant%0d", n), m_exp, 4'(4'b0001 << ii));
      tick();
      expect_state($sformatf("t2_hold%0d", n), m_exp, 4'b0000);
      pkt_done = 4'(4'b0001 << ii);
      tick();
      pkt_done = '0;
      expect_state($sformatf("t2_done%0d", n), 16'h0000, 4'b0000);
      tick();
    end

    // Rotation: all four matched in one cycle.
    reset_dut();
    voq_req = 16'h1842;
    tick();
    expect_state("t3_full", 16'h1842, 4'b1111);

    // Contention on out1 resolved over two cycles, then g[1]=2 favours in2.
    reset_dut();
    voq_req = 16'h0023;
    tick();
    expect_state("t4_c1", 16'h0001, 4'b0001);
    tick();
    expect_state("t4_c2", 16'h0021, 4'b0010);
    voq_req  = '0;
    pkt_done = 4'b0011;
    tick();
    pkt_done = '0;
    expect_state("t4_rel", 16'h0000, 4'b0000);
    voq_req = 16'h0202;
    tick();
    expect_state("t4_gptr", 16'h0200, 4'b0100);
    tick();
    expect_state("t4_gptr_hold", 16'h0200, 4'b0000);

    // Lock survives out_en drop; disabled output gets no new match.
    reset_dut();
    voq_req = 16'h0800;
    tick();
    expect_state("t5_lock", 16'h0800, 4'b0100);
    out_en  = 4'b0111;
    voq_req = '0;
    tick();
    expect_state("t5_held1", 16'h0800, 4'b0000);
    tick();
    expect_state("t5_held2", 16'h0800, 4'b0000);
    pkt_done = 4'b0100;
    tick();
    pkt_done = '0;
    expect_state("t5_rel", 16'h0000, 4'b0000);
    voq_req = 16'h0808;
    tick();
    expect_state("t5_blocked1", 16'h0000, 4'b0000);
    tick();
    expect_state("t5_blocked2", 16'h0000, 4'b0000);
    out_en = 4'hf;
    tick();
    expect_state("t5_reenable", 16'h0008, 4'b0001);

    // Asynchronous reset mid-packet, then rematch from pointer 0.
    reset_dut();
    voq_req = 16'h0421;
    tick();
    expect_state("t6_locks", 16'h0421, 4'b0111);
    tick();
    expect_state("t6_hold", 16'h0421, 4'b0000);
    rst_n   = 1'b0;
    voq_req = 16'h1421;
    #1;
    expect_state("t6_async", 16'h0000, 4'b0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    expect_state("t6_rematch", 16'h0421, 4'b0111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
